// File: rtl/hams_pkg.sv
// Shared types and constants for the HAMS bitonic sort controller.
//   NUM_ELEMENTS : batch width of the sort network (power of two, >= 2)
//   PIPELINES    : default network latency in cycles
//   pair         : 32-bit sortable element
//   pair_vec     : one batch, index 0 = first accepted / smallest sorted
//   batch_tag    : per-batch padding count and end-of-job flag
package hams_pkg;
    localparam int NUM_ELEMENTS = 4;
    localparam int PIPELINES    = 1;
    localparam int IDX_W        = $clog2(NUM_ELEMENTS);

    typedef logic [31:0] pair;

    localparam logic [31:0] PAD_KEY = '1;

    typedef struct packed {
        logic [IDX_W-1:0] pad_cnt;
        logic             last;
    } batch_tag;

    typedef pair [NUM_ELEMENTS-1:0] pair_vec;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;
endpackage

// File: rtl/hams_sort_ctrl_if.sv
// Bundle of the input stream, network and output stream signals of the
// sort controller.
//   master : controller side (hams_sort_ctrl)
//   slave  : environment side (upstream source, network, downstream sink)
interface hams_sort_ctrl_if;
    import hams_pkg::*;

    logic    s_valid;
    logic    s_ready;
    pair     s_data;
    logic    s_last;
    logic    net_valid;
    pair_vec net_data;
    pair_vec net_res;
    logic    m_valid;
    logic    m_ready;
    pair     m_data;
    logic    m_last;
    logic    busy;

    modport master (
        input  s_valid, s_data, s_last, net_res, m_ready,
        output s_ready, net_valid, net_data, m_valid, m_data, m_last, busy
    );

    modport slave (
        output s_valid, s_data, s_last, net_res, m_ready,
        input  s_ready, net_valid, net_data, m_valid, m_data, m_last, busy
    );
endinterface

// File: rtl/hams_sort_obuf.sv
// Output buffer: FIFO of sorted batches with their tags.
//   clk, rst_n          : clock, async active-low reset
//   push, push_data/tag : write one batch at the tail
//   pop                 : drop the head batch
//   head_data/tag       : batch at the head
//   count               : number of stored batches
module hams_sort_obuf
    import hams_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  pair_vec          push_data,
    input  batch_tag         push_tag,
    input  logic             pop,
    output pair_vec          head_data,
    output batch_tag         head_tag,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    pair_vec          data_mem [DEPTH];
    batch_tag         tag_mem  [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= push_data;
            tag_mem[wr_ptr]  <= push_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = data_mem[rd_ptr];
    assign head_tag  = tag_mem[rd_ptr];
endmodule

// File: rtl/hams_sort_ctrl.sv
// Sequencing controller for the HAMS bitonic sort network.
// Packs the input stream into NUM_ELEMENTS-wide batches (padding short
// batches with PAD_KEY), issues them to a fixed-latency network under
// credit control, buffers the sorted results and re-serializes them
// with the padding removed.
//   clk, rst_n : clock, async active-low reset
//   bus        : stream in (s_*), network (net_*), stream out (m_*), busy
//
//   state | meaning
//   ------+----------------------------------------------------------
//   FILL  | accepting elements into batch[idx]
//   HOLD  | batch complete, waiting for a credit to issue it
module hams_sort_ctrl
    import hams_pkg::*;
#(
    parameter int LATENCY    = PIPELINES,
    parameter int OBUF_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    hams_sort_ctrl_if.master bus
);
    localparam int CNT_W = $clog2(OBUF_DEPTH + 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] last_idx;
    pair_vec          batch;
    batch_tag         cur_tag;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] obuf_count;
    logic [CNT_W:0]   used;
    logic             credit_ok;
    logic             issue;
    logic             cap_valid;
    batch_tag         cap_tag;
    pair_vec          head_data;
    batch_tag         head_tag;
    logic             m_fire;
    logic             pop;

    assign used      = {1'b0, inflight} + {1'b0, obuf_count};
    assign credit_ok = used < (CNT_W + 1)'(OBUF_DEPTH);
    assign issue     = (state == HOLD) & credit_ok;

    assign bus.s_ready   = (state == FILL);
    assign bus.net_valid = issue;
    assign bus.net_data  = batch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FILL;
            idx     <= '0;
            batch   <= '0;
            cur_tag <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (bus.s_valid) begin
                        batch[idx] <= bus.s_data;
                        if (idx == IDX_W'(NUM_ELEMENTS - 1) || bus.s_last) begin
                            for (int i = 0; i < NUM_ELEMENTS; i++) begin
                                if (i > int'(idx)) batch[i] <= PAD_KEY;
                            end
                            cur_tag.pad_cnt <= IDX_W'(NUM_ELEMENTS - 1) - idx;
                            cur_tag.last    <= bus.s_last;
                            state           <= HOLD;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (credit_ok) begin
                        idx   <= '0;
                        state <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    // The tag travels alongside the batch through the network so the
    // capture point knows which result belongs to which job boundary.
    if (LATENCY == 0) begin : g_comb_net
        assign cap_valid = issue;
        assign cap_tag   = cur_tag;
    end else begin : g_pipe_net
        logic [LATENCY-1:0] sr_valid;
        batch_tag           sr_tag [LATENCY];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sr_valid <= '0;
                for (int i = 0; i < LATENCY; i++) sr_tag[i] <= '0;
            end else begin
                sr_valid[0] <= issue;
                sr_tag[0]   <= cur_tag;
                for (int i = 1; i < LATENCY; i++) begin
                    sr_valid[i] <= sr_valid[i-1];
                    sr_tag[i]   <= sr_tag[i-1];
                end
            end
        end

        assign cap_valid = sr_valid[LATENCY-1];
        assign cap_tag   = sr_tag[LATENCY-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else if (issue && !cap_valid) begin
            inflight <= inflight + 1'b1;
        end else if (cap_valid && !issue) begin
            inflight <= inflight - 1'b1;
        end
    end

    hams_sort_obuf #(.DEPTH(OBUF_DEPTH)) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cap_valid),
        .push_data (bus.net_res),
        .push_tag  (cap_tag),
        .pop       (pop),
        .head_data (head_data),
        .head_tag  (head_tag),
        .count     (obuf_count)
    );

    // Padding sorts to the top of the batch, so only indices up to
    // last_idx carry real data.
    assign last_idx    = IDX_W'(NUM_ELEMENTS - 1) - head_tag.pad_cnt;
    assign bus.m_valid = (obuf_count != '0);
    assign m_fire      = bus.m_valid & bus.m_ready;
    assign pop         = m_fire & (rd_idx == last_idx);
    assign bus.m_data  = bus.m_valid ? head_data[rd_idx] : '0;
    assign bus.m_last  = bus.m_valid & head_tag.last & (rd_idx == last_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx <= '0;
        end else if (m_fire) begin
            rd_idx <= pop ? '0 : rd_idx + 1'b1;
        end
    end

    assign bus.busy = (state != FILL) | (idx != '0) | (inflight != '0) | (obuf_count != '0);
endmodule

// File: doc/hams_sort_ctrl.md
# hams_sort_ctrl

Sequencing controller for the HAMS bitonic sort network. It accepts a stream of `pair` elements and packs them into `NUM_ELEMENTS`-wide batches, padding a short final batch with max-key fillers. It issues each batch to the fixed-latency, non-stallable network and tracks in-flight batches with credits. Sorted batches are captured into an output buffer and re-serialized as a stream with the padding removed.

## Interface
- `NUM_ELEMENTS`, `hams_pkg::NUM_ELEMENTS` (4): batch width; power of two, ≥2.
- `LATENCY`, `hams_pkg::PIPELINES` (1): network latency in cycles from `net_valid` to result; 0 = combinational network.
- `OBUF_DEPTH`, 2: output buffer capacity in batches; ≥1.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset; **asynchronous, active-low**.
- `s_valid` in 1: input element valid.
- `s_ready` out 1: input element accepted when `s_valid & s_ready`.
- `s_data` in `pair` (32): input element.
- `s_last` in 1: final element of a job.
- `net_valid` out 1: batch presented to the network this cycle.
- `net_data` out `pair [NUM_ELEMENTS-1:0]`: batch to the network.
- `net_res` in `pair [NUM_ELEMENTS-1:0]`: network output, ascending, index 0 = smallest.
- `m_valid` out 1: output element valid.
- `m_ready` in 1: downstream accepts.
- `m_data` out `pair`: output element.
- `m_last` out 1: final real element of a job.
- `busy` out 1: any batch filling, held, in flight or buffered.

## Operation
- **FSM `FILL`**: `s_ready`=1. Accepted elements are written to `batch[idx]` and `idx` increments. On acceptance with `idx==NUM_ELEMENTS-1` or `s_last`:
  - slots `idx+1..N-1` are padded with `32'hFFFF_FFFF`;
  - `pad_cnt = N-1-idx` is recorded;
  - `last_flag = s_last` is recorded;
  - the FSM moves to `HOLD`.
- **`HOLD`**: `s_ready`=0.
  - `credit = OBUF_DEPTH - inflight - obuf_count`.
  - When `credit>0`: `net_valid`=1 for exactly one cycle and `net_data = batch`.
  - `pad_cnt`/`last_flag` are pushed into a `LATENCY`-deep side shift register, `idx` is cleared, and the FSM returns to `FILL`.
- **Capture**: the result is captured from `net_res` into the obuf tail along with its `pad_cnt`/`last_flag`.
  - `LATENCY`=0: captured in the issue cycle.
  - Otherwise: captured in the cycle the shift-register valid bit emerges.
  - Credits guarantee that the capture never finds the obuf full.
- **Drain**: `m_data = obuf[head][rd_idx]`.
  - `m_valid` = obuf not empty.
  - `m_last = last_flag & (rd_idx == N-1-pad_cnt)`.
  - On `m_valid & m_ready`: `rd_idx` increments. At `N-1-pad_cnt`, `rd_idx` clears and the head pops.
  - Padding is never emitted. Ties between real `FFFF_FFFF` keys and padding are harmless, because padding is dropped by count.
- **Simultaneous push and pop** in the same cycle: `obuf_count` is unchanged. Pointers wrap modulo `OBUF_DEPTH`.
- **`s_last` on a full batch** (`idx==N-1`): `pad_cnt=0`, `last_flag=1`.
- **`busy`** = `(state!=FILL) | (idx!=0) | (inflight!=0) | (obuf_count!=0)`.

## Timing
- **Reset values**: `s_ready`=1, `net_valid`=0, `net_data`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0. State `FILL`; all counters and pointers 0.
- **Reset mid-operation**: all batches are discarded, in-flight ones included. Network results arriving after reset are ignored.
- **Input throughput**: one batch per `N+1` cycles at most (one `HOLD` cycle minimum).
- **Latency**: the last accepted element at cycle t leads to `net_valid` at t+1. The first `m_valid` is at t+2+`LATENCY` when credit is available.
- **Backpressure**: outputs (`m_data`, `m_last`) are held stable while `m_valid & !m_ready`. With `OBUF_DEPTH` batches outstanding, `HOLD` stalls.
- **Network**: `net_valid` is a single-cycle pulse. The network never stalls and outputs `net_res` exactly `LATENCY` cycles later.

## Structure
- `hams_pkg` additions:
  - `localparam logic [31:0] PAD_KEY = '1`;
  - `typedef struct packed {logic [$clog2(NUM_ELEMENTS)-1:0] pad_cnt; logic last;} batch_tag;`
  - `typedef pair [NUM_ELEMENTS-1:0] pair_vec;`
- Sub-module `hams_sort_obuf`: the batch FIFO of `pair_vec` + `batch_tag` with push/pop/count. The FSM, credit logic, latency shift register and serializer stay in the top module.

## Test plan
- **Full batch**: 7,3,9,1 (last on 1) → `net_valid` one cycle later with {7,3,9,1}. Output 1,3,7,9; `m_last` only on 9.
- **Short batch**: 5,2 (last on 2) → `net_data` {5,2,FFFF_FFFF,FFFF_FFFF}. Output 2,5 only; `m_last` on 5.
- **Backpressure**: `m_ready`=0 while feeding 12 elements → exactly `OBUF_DEPTH`(2) batches issue, then `HOLD` stalls and `s_ready`=0. Releasing `m_ready` drains all 12 values in order with no loss.
- **Max-key data**: FFFF_FFFF,0 (last) → output 0,FFFF_FFFF; exactly 2 elements.
- **Reset mid-flight**: assert `rst_n`=0 one cycle after `net_valid` → all outputs at reset values. A subsequent job 4,3,2,1 outputs 1,2,3,4 with no stale data.
- **Back-to-back jobs**: jobs {8} and {6,5,4,3,2} → outputs 8(last), then 3,4,5,6 and 2(last).
